// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU: next-PC select codes,
// fetch FSM states and reset defaults.
package cpu_pkg;

   typedef enum logic [1:0] {
      NPC_SEQ = 2'b00,
      NPC_BR  = 2'b01,
      NPC_J   = 2'b10,
      NPC_JR  = 2'b11
   } npc_sel_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_FETCH = 2'b01,
      ST_DONE  = 2'b10
   } fetch_state_e;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
   localparam int          IM_LAT_DEFAULT   = 1;

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC selection: sequential, branch, jump and register jump,
// plus a flag for a register-jump target that is not word aligned.
module npc_calc
   import cpu_pkg::*;
(
   input  logic [31:0] pc,
   input  npc_sel_e    npc_sel,
   input  logic        br_taken,
   input  logic [15:0] imm16,
   input  logic [25:0] target26,
   input  logic [31:0] rs_val,
   output logic [31:0] npc,
   output logic        misalign
);

   logic [31:0] br_off;

   // Branch offset is counted in words, so sign-extend and scale by 4.
   assign br_off = {{14{imm16[15]}}, imm16, 2'b00};

   // NOTE: every output of a combinational block gets a default first,
   // otherwise an unassigned path infers a latch.
   always_comb begin
      npc      = pc;
      misalign = 1'b0;
      case (npc_sel)
         NPC_SEQ: npc = pc + 32'd4;
         NPC_BR:  if (br_taken) npc = pc + br_off;
         NPC_J:   npc = {pc[31:28], target26, 2'b00};
         NPC_JR: begin
            npc      = {rs_val[31:2], 2'b00};
            misalign = |rs_val[1:0];
         end
         default: npc = pc;
      endcase
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory word
// address from a latched fetch address and captures the returned word into IR.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          IM_LAT   = IM_LAT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_req,
   input  logic        pc_wr,
   input  logic [1:0]  npc_sel,
   input  logic        br_taken,
   input  logic [15:0] imm16,
   input  logic [25:0] target26,
   input  logic [31:0] rs_val,
   output logic [9:0]  im_addr,
   input  logic [31:0] im_dout,
   output logic [31:0] ir,
   output logic [31:0] pc,
   output logic        busy,
   output logic        fetch_done,
   output logic        addr_err,
   output logic [31:0] instr_cnt
);

   localparam int             LAT_W    = (IM_LAT > 1) ? $clog2(IM_LAT) : 1;
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(IM_LAT - 1);

   fetch_state_e     state_q, state_d;
   logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
   logic [9:0]       fa_q, fa_d;
   logic [31:0]      pc_q, pc_d;
   logic [31:0]      ir_q, ir_d;
   logic [31:0]      cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             done_q, done_d;
   logic [31:0]      npc;
   logic             misalign;
   logic             capture;

   npc_calc u_npc_calc (
      .pc       (pc_q),
      .npc_sel  (npc_sel_e'(npc_sel)),
      .br_taken (br_taken),
      .imm16    (imm16),
      .target26 (target26),
      .rs_val   (rs_val),
      .npc      (npc),
      .misalign (misalign)
   );

   always_comb begin
      state_d   = state_q;
      lat_cnt_d = lat_cnt_q;
      fa_d      = fa_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      done_d    = 1'b0;
      capture   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (fetch_req) begin
               fa_d      = pc_q[11:2];
               lat_cnt_d = '0;
               state_d   = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (lat_cnt_q == LAT_LAST) begin
               capture = 1'b1;
               state_d = ST_DONE;
            end else begin
               lat_cnt_d = lat_cnt_q + 1'b1;
            end
         end
         ST_DONE: begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (capture) begin
         ir_d  = im_dout;
         cnt_d = cnt_q + 32'd1;
         pc_d  = pc_q + 32'd4;
      end

      // A control-FSM PC write overrides the post-fetch increment.
      if (pc_wr) begin
         pc_d = npc;
         if (misalign) err_d = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   // NOTE: all control and datapath registers here are reset; there is no
   // memory array in this block that would need to be left unreset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         lat_cnt_q <= '0;
         fa_q      <= RESET_PC[11:2];
         pc_q      <= RESET_PC;
         ir_q      <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         lat_cnt_q <= lat_cnt_d;
         fa_q      <= fa_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         done_q    <= done_d;
      end
   end

   // The memory address comes only from the latched fetch address.
   assign im_addr    = fa_q;
   assign ir         = ir_q;
   assign pc         = pc_q;
   assign busy       = (state_q == ST_FETCH);
   assign fetch_done = done_q;
   assign addr_err   = err_q;
   assign instr_cnt  = cnt_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the multicycle CPU. Directly upstream of the 4 KB instruction memory: drives its word address, then captures the returned word into the instruction register (IR).
- Owns the PC: sequential increment, branch, jump and jr target selection.
- Handshakes with the main control FSM through a fetch request/done pair.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- IM_LAT, 1, cycles from address presentation to IR capture (1 for the combinational memory; 2–4 reserved for a future synchronous memory).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- fetch_req  in  1  control FSM requests one instruction fetch.
- pc_wr  in  1  control FSM PC update strobe.
- npc_sel  in  2  00 seq (PC+4), 01 branch, 10 jump, 11 jr.
- br_taken  in  1  branch condition from ALU, qualifies npc_sel=01.
- imm16  in  16  branch offset, in words.
- target26  in  26  jump index.
- rs_val  in  32  jr target register value.
- im_addr  out  10  word address to instruction memory (addr[11:2]).
- im_dout  in  32  instruction word from memory.
- ir  out  32  instruction register.
- pc  out  32  current PC.
- busy  out  1  fetch in progress.
- fetch_done  out  1  one-cycle pulse when IR updated.
- addr_err  out  1  sticky: misaligned jr target seen.
- instr_cnt  out  32  retired fetch count.

Behaviour:
- Reset (async, rst=0):
  - pc=RESET_PC, ir=0, busy=0, fetch_done=0, addr_err=0, instr_cnt=0.
  - FSM to IDLE; lat_cnt=0; fa (latched fetch address) = RESET_PC[11:2].
  - Reset mid-fetch aborts the fetch: IR is not written and no fetch_done is issued.
- FSM states: IDLE, FETCH, DONE.
  - IDLE: on fetch_req=1, latch fa=pc[11:2], lat_cnt=0, go to FETCH.
  - FETCH: busy=1. Increment lat_cnt each cycle. When lat_cnt==IM_LAT-1: ir<=im_dout, pc<=pc+4, instr_cnt<=instr_cnt+1, go to DONE.
  - DONE: fetch_done=1 for exactly one cycle, busy=0, go to IDLE. fetch_req in DONE is ignored; a new fetch needs fetch_req in IDLE.
- Latency: with IM_LAT=1, fetch_req sampled at edge N → IR valid and fetch_done=1 after edge N+2, i.e. 2 cycles per fetch.
- fetch_req during FETCH is ignored; no queueing.
- im_addr is always driven from fa, never directly from pc. A mid-fetch pc_wr therefore cannot change the word being fetched.
- PC update on pc_wr=1 (any state), computed from the current pc value (already PC+4 after fetch):
  - seq: pc+4.
  - branch: pc + (sign_ext(imm16)<<2) if br_taken, else pc unchanged.
  - jump: {pc[31:28], target26, 2'b00}.
  - jr: {rs_val[31:2], 2'b00}. If rs_val[1:0]!=0, set addr_err=1. addr_err stays set until reset.
- Simultaneous pc_wr and fetch completion: pc_wr result wins. ir and instr_cnt still update.
- Arithmetic: all PC math is 32-bit modulo; 0xFFFF_FFFC+4 wraps to 0.
- Word addressing: im_addr uses pc[11:2] only, so the 4 KB window wraps silently.
- instr_cnt wraps from 0xFFFF_FFFF to 0.

Decomposition:
- Shared package (cpu_pkg):
  - npc_sel encodings NPC_SEQ/NPC_BR/NPC_J/NPC_JR.
  - FSM state encodings.
  - RESET_PC default.
- One sub-module, npc_calc: combinational next-PC mux and adders (pc, npc_sel, br_taken, imm16, target26, rs_val → npc, misalign).
- FSM, IR, counter and PC register stay in fetch_unit.

Test Plan:
- Reset then fetch_req pulse, im_dout=0x2008_0005 at word 0 → im_addr=0, ir=0x2008_0005, fetch_done pulses 2 cycles after request, pc=0x3004, instr_cnt=1.
- pc=0x3004, pc_wr, npc_sel=01, br_taken=1, imm16=0xFFFF → pc=0x3000. Same with br_taken=0 → pc stays 0x3004.
- npc_sel=10, target26=0x0000C10, pc=0x3008 → pc=0x0000_3040. npc_sel=11, rs_val=0x3021 → pc=0x3020, addr_err=1, and it stays 1 across later fetches.
- pc_wr jump asserted on the fetch-completion cycle → ir loads the old-address word, and pc holds the jump target, not old PC+4.
- Reset asserted in FETCH → immediate pc=0x3000, ir=0, busy=0, and no fetch_done. fetch_req held high during FETCH → exactly one fetch completes.
- IM_LAT=3 build → fetch_done 4 cycles after request. im_dout changed in cycle 1 is ignored; only the value present when lat_cnt==IM_LAT-1 is captured.
